// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: active-high digit patterns,
// the dark cathode/anode bus values and the scan controller state type.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  // Cathode bus value with every segment off (bus is active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high {a,b,c,d,e,f,g} segment decoder,
// shared by the scan controller and the single-digit display.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_seg = '0;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = '0;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit 7-segment scan controller: time-multiplexes one cathode bus over
// eight anodes with anti-ghost blanking and frame-synchronous (tear-free) updates.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_START = PW'(BLANK_CYC);

  scan_state_t r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [2:0]    r_digit, w_digit_nxt;
  logic [31:0]   r_disp, w_disp_nxt;
  logic [31:0]   r_pend, w_pend_nxt;
  logic          r_pend_vld, w_pend_vld_nxt;
  logic          w_frame_done_nxt;
  logic          w_past_blank, w_drive;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_hi;
  logic [7:0]    r_an, w_an_nxt;
  logic [6:0]    r_seg, w_seg_nxt;
  logic          r_dp, w_dp_nxt;
  logic          r_frame_done;

  always_comb begin
    w_state_nxt      = r_state;
    w_presc_nxt      = r_presc;
    w_digit_nxt      = r_digit;
    w_disp_nxt       = r_disp;
    w_pend_nxt       = r_pend;
    w_pend_vld_nxt   = r_pend_vld;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_presc_nxt = '0;
        w_digit_nxt = '0;
        if (en) begin
          w_state_nxt = ST_SCAN;
          if (r_pend_vld) w_disp_nxt = r_pend;
          w_pend_vld_nxt = 1'b0;
        end
        // A direct load is newer than anything pending, so pending is dropped.
        if (load) begin
          w_disp_nxt     = data;
          w_pend_vld_nxt = 1'b0;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
          w_presc_nxt = '0;
          w_digit_nxt = '0;
          if (load) begin
            w_pend_nxt     = data;
            w_pend_vld_nxt = 1'b1;
          end
        end else begin
          if (r_presc == PRESC_LAST) begin
            w_presc_nxt = '0;
            w_digit_nxt = r_digit + 3'd1;
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
          if ((r_presc == PRESC_LAST) && (r_digit == 3'd7)) begin
            w_frame_done_nxt = 1'b1;
            w_pend_vld_nxt   = 1'b0;
            if (load)            w_disp_nxt = data;
            else if (r_pend_vld) w_disp_nxt = r_pend;
          end else if (load) begin
            w_pend_nxt     = data;
            w_pend_vld_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  if (BLANK_CYC == 0) begin : g_no_blank
    assign w_past_blank = 1'b1;
  end else begin : g_blank
    assign w_past_blank = (w_presc_nxt >= BLANK_START);
  end

  // Outputs are decoded from next-state values so the registered pins line up
  // exactly with the registered prescaler and digit counter.
  assign w_drive  = (w_state_nxt == ST_SCAN) && w_past_blank && !blank_mask[w_digit_nxt];
  assign w_nibble = w_disp_nxt[{w_digit_nxt, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_hi)
  );

  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    if (w_drive) begin
      w_an_nxt  = ~(8'b1 << w_digit_nxt);
      w_seg_nxt = ~w_seg_hi;
      w_dp_nxt  = ~dp_mask[w_digit_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_digit      <= '0;
      // NOTE: the data registers are reset too, so a display enabled before any load shows zeros.
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_digit      <= w_digit_nxt;
      r_disp       <= w_disp_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign digit_idx  = r_digit;
  assign frame_done = r_frame_done;

endmodule
